// File: rtl/ps2_scan_decoder.sv
// PS/2 keyboard receiver: synchronise and filter the pins, check 11-bit frames,
// fold E0/F0 prefixes into key events, and buffer the events in a FIFO.
module ps2_scan_decoder #(
  parameter int FILTER_CYCLES  = 19,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        kclk,
  input  logic        kdata,
  output logic        ev_valid,
  input  logic        ev_ready,
  output logic [7:0]  ev_code,
  output logic        ev_ext,
  output logic        ev_brk,
  output logic [15:0] keycode,
  output logic        keycode_stb,
  output logic        err_parity,
  output logic        err_frame,
  output logic        overflow
);

  localparam int FW = $clog2(FILTER_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int AW = $clog2(FIFO_DEPTH);

  // Line 0 is kclk, line 1 is kdata.
  logic [1:0]    sync1, sync2, filt;
  logic [FW-1:0] fcnt [2];
  logic          kclk_d;
  logic          kclk_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 2'b11;
      sync2  <= 2'b11;
      filt   <= 2'b11;
      fcnt[0] <= '0;
      fcnt[1] <= '0;
      kclk_d <= 1'b1;
    end else begin
      sync1  <= {kdata, kclk};
      sync2  <= sync1;
      kclk_d <= filt[0];
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] != filt[i]) begin
          // The FILTER_CYCLES-th consecutive differing sample commits the new level.
          if (fcnt[i] == FW'(FILTER_CYCLES - 1)) begin
            filt[i] <= sync2[i];
            fcnt[i] <= '0;
          end else begin
            fcnt[i] <= fcnt[i] + 1'b1;
          end
        end else begin
          fcnt[i] <= '0;
        end
      end
    end
  end

  assign kclk_fall = kclk_d & ~filt[0];

  // Frame receiver: shreg collects data LSB first, parity ends up in bit 8.
  logic [3:0]    bit_idx;
  logic [8:0]    shreg;
  logic [TW-1:0] idle_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_idx     <= '0;
      shreg       <= '0;
      idle_cnt    <= '0;
      keycode     <= '0;
      keycode_stb <= 1'b0;
      err_parity  <= 1'b0;
      err_frame   <= 1'b0;
    end else begin
      keycode_stb <= 1'b0;
      err_parity  <= 1'b0;
      err_frame   <= 1'b0;
      if (kclk_fall) begin
        idle_cnt <= '0;
        if (bit_idx == 4'd0) begin
          if (filt[1]) err_frame <= 1'b1;
          else         bit_idx   <= 4'd1;
        end else if (bit_idx == 4'd10) begin
          bit_idx <= 4'd0;
          if (!filt[1]) begin
            err_frame <= 1'b1;
          end else if (!(^shreg)) begin
            err_parity <= 1'b1;
          end else begin
            keycode     <= {keycode[7:0], shreg[7:0]};
            keycode_stb <= 1'b1;
          end
        end else begin
          shreg   <= {filt[1], shreg[8:1]};
          bit_idx <= bit_idx + 4'd1;
        end
      end else if (bit_idx != 4'd0) begin
        if (idle_cnt == TW'(TIMEOUT_CYCLES)) begin
          bit_idx   <= 4'd0;
          idle_cnt  <= '0;
          err_frame <= 1'b1;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end else begin
        idle_cnt <= '0;
      end
    end
  end

  // Prefix decoder: the byte just accepted is keycode[7:0] while keycode_stb is high.
  logic       ext_pend, brk_pend;
  logic       push;
  logic [9:0] push_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext_pend  <= 1'b0;
      brk_pend  <= 1'b0;
      push      <= 1'b0;
      push_data <= '0;
    end else begin
      push <= 1'b0;
      if (err_parity || err_frame) begin
        ext_pend <= 1'b0;
        brk_pend <= 1'b0;
      end else if (keycode_stb) begin
        if (keycode[7:0] == 8'hE0) begin
          ext_pend <= 1'b1;
        end else if (keycode[7:0] == 8'hF0) begin
          brk_pend <= 1'b1;
        end else begin
          push      <= 1'b1;
          push_data <= {ext_pend, brk_pend, keycode[7:0]};
          ext_pend  <= 1'b0;
          brk_pend  <= 1'b0;
        end
      end
    end
  end

  // Handshake: an event transfers on a clock edge where ev_valid && ev_ready;
  // ev_valid never drops and ev_* never change while ev_valid && !ev_ready.
  logic [9:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, do_push, do_pop;

  assign full     = (count == (AW+1)'(FIFO_DEPTH));
  assign ev_valid = (count != '0);
  assign do_pop   = ev_valid && ev_ready;
  assign do_push  = push && (!full || do_pop);
  assign ev_code  = mem[rd_ptr][7:0];
  assign ev_brk   = mem[rd_ptr][8];
  assign ev_ext   = mem[rd_ptr][9];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= push && full && !do_pop;
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

endmodule
